// File: rtl/mux_4x1.sv
// mux_4x1: four-source line multiplexer with a 2-bit select.
//
// m_out is the zero-latency selected source. m_out_q, sel_q and q_valid form
// a one-stage registered copy for downstream pipeline stages.
//
// Ports:
//   clk      rising-edge clock for the registered path
//   rst_n    synchronous active-low reset for the registered path
//   in_0..3  data sources, chosen by select = 00/01/10/11
//   select   source select code
//   en       capture enable for the registered path
//   m_out    combinational selected data
//   m_out_q  registered selected data
//   q_valid  high when m_out_q holds data captured under en
//   sel_q    select code captured together with m_out_q
module mux_4x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [1:0]       select,
  input  logic             en,
  output logic [WIDTH-1:0] m_out,
  output logic [WIDTH-1:0] m_out_q,
  output logic             q_valid,
  output logic [1:0]       sel_q
);

  // A select carrying X/Z matches none of the explicit items and falls to the
  // default, so an unknown code yields all-zeros instead of propagating X.
  always_comb begin
    m_out = '0;
    case (select)
      2'b00:   m_out = in_0;
      2'b01:   m_out = in_1;
      2'b10:   m_out = in_2;
      2'b11:   m_out = in_3;
      default: m_out = '0;
    endcase
  end

  // Reset wins over en. With en low the data and select hold, but q_valid
  // drops so downstream sees that nothing new was captured on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_out_q <= '0;
      sel_q   <= 2'b00;
      q_valid <= 1'b0;
    end else if (en) begin
      m_out_q <= m_out;
      sel_q   <= select;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: one WIDTH=1 and one WIDTH=8 instance
// sharing clock, reset, enable and select, driven with directed vectors.
module tb_mux_4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] select;

  logic       a_0, a_1, a_2, a_3;
  logic       m1, mq1, v1;
  logic [1:0] s1;

  logic [7:0] b_0, b_1, b_2, b_3;
  logic [7:0] m8, mq8;
  logic       v8;
  logic [1:0] s8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_4x1 #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_0    (a_0),
    .in_1    (a_1),
    .in_2    (a_2),
    .in_3    (a_3),
    .select  (select),
    .en      (en),
    .m_out   (m1),
    .m_out_q (mq1),
    .q_valid (v1),
    .sel_q   (s1)
  );

  mux_4x1 #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_0    (b_0),
    .in_1    (b_1),
    .in_2    (b_2),
    .in_3    (b_3),
    .select  (select),
    .en      (en),
    .m_out   (m8),
    .m_out_q (mq8),
    .q_valid (v8),
    .sel_q   (s8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [3:0] d);
    {a_3, a_2, a_1, a_0} = d;
  endtask

  logic [3:0] dat;
  logic [7:0] bytes [4];

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    select = 2'b00;
    set_a(4'b0000);
    b_0 = 8'h00; b_1 = 8'h00; b_2 = 8'h00; b_3 = 8'h00;

    // Bring registered path to a known state.
    tick();
    tick();
    check("rst_mq1", {7'd0, mq1}, 8'h00);
    check("rst_v1",  {7'd0, v1},  8'h00);
    check("rst_s1",  {6'd0, s1},  8'h00);
    check("rst_mq8", mq8, 8'h00);

    // Test 1: one-hot data, selected bit is 1, no clock edge needed.
    rst_n = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      set_a(4'b0001 << i);
      #1;
      check($sformatf("onehot_sel%0d", i), {7'd0, m1}, 8'h01);
      #9;
    end

    // Test 2: exclusivity, then one-cold sweep over every select code.
    select = 2'b01;
    set_a(4'b1101);
    #1;
    check("excl_sel1", {7'd0, m1}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      dat = ~(4'b0001 << i);
      set_a(dat);
      for (int j = 0; j < 4; j++) begin
        select = 2'(j);
        #1;
        check($sformatf("onecold_z%0d_sel%0d", i, j), {7'd0, m1}, {7'd0, dat[j]});
      end
    end

    // Test 3: reset held two edges with en=1; m_out unaffected.
    rst_n  = 1'b0;
    en     = 1'b1;
    select = 2'b11;
    set_a(4'b1000);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rsthold%0d_mq1", k), {7'd0, mq1}, 8'h00);
      check($sformatf("rsthold%0d_s1", k),  {6'd0, s1},  8'h00);
      check($sformatf("rsthold%0d_v1", k),  {7'd0, v1},  8'h00);
      check($sformatf("rsthold%0d_m1", k),  {7'd0, m1},  8'h01);
    end

    // Test 4: capture, then hold with en=0.
    rst_n  = 1'b1;
    en     = 1'b1;
    select = 2'b10;
    set_a(4'b0100);
    tick();
    check("cap_mq1", {7'd0, mq1}, 8'h01);
    check("cap_s1",  {6'd0, s1},  8'h02);
    check("cap_v1",  {7'd0, v1},  8'h01);
    en     = 1'b0;
    select = 2'b00;
    set_a(4'b0000);
    #1;
    check("between_mq1", {7'd0, mq1}, 8'h01);
    tick();
    check("hold_mq1", {7'd0, mq1}, 8'h01);
    check("hold_s1",  {6'd0, s1},  8'h02);
    check("hold_v1",  {7'd0, v1},  8'h00);
    check("hold_m1",  {7'd0, m1},  8'h00);

    // Test 5: 8-bit data per select, then enabled capture with select=01.
    b_0 = 8'hA5; b_1 = 8'h3C; b_2 = 8'hFF; b_3 = 8'h00;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      select = 2'(i);
      #1;
      check($sformatf("w8_sel%0d", i), m8, bytes[i]);
    end
    select = 2'b01;
    en     = 1'b1;
    tick();
    check("w8_cap_mq8", mq8, 8'h3C);
    check("w8_cap_s8",  {6'd0, s8}, 8'h01);
    check("w8_cap_v8",  {7'd0, v8}, 8'h01);

    // Test 6: capture 8'hFF, then reset and en on the same edge.
    select = 2'b10;
    tick();
    check("pri_pre_mq8", mq8, 8'hFF);
    rst_n = 1'b0;
    en    = 1'b1;
    tick();
    check("pri_mq8", mq8, 8'h00);
    check("pri_v8",  {7'd0, v8}, 8'h00);
    check("pri_s8",  {6'd0, s8}, 8'h00);
    check("pri_m8",  m8, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
